// File: rtl/debounce_ctrl.sv
// Debounce control: synchronises a bouncy input and sequences an external timer
// to produce a clean level, edge strobes and a saturating glitch count.
module debounce_ctrl #(
  parameter int SYNC_STAGES = 2,
  parameter bit INIT_LEVEL  = 1'b0,
  parameter int GLITCH_W    = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                raw_in,
  input  logic                timer_done,
  output logic                timer_en,
  output logic                db_out,
  output logic                rise_pulse,
  output logic                fall_pulse,
  output logic [GLITCH_W-1:0] glitch_cnt
);

  typedef enum logic [1:0] {
    STABLE_LOW  = 2'b00,
    WAIT_HIGH   = 2'b01,
    STABLE_HIGH = 2'b10,
    WAIT_LOW    = 2'b11
  } state_t;

  localparam state_t              RESET_STATE = INIT_LEVEL ? STABLE_HIGH : STABLE_LOW;
  localparam logic [GLITCH_W-1:0] GLITCH_MAX  = '1;

  function automatic logic [GLITCH_W-1:0] sat_inc(input logic [GLITCH_W-1:0] v);
    return (v == GLITCH_MAX) ? v : v + 1'b1;
  endfunction

  logic [SYNC_STAGES-1:0] sync_p0;
  logic                   s_in;
  state_t                 state;
  state_t                 state_nxt;
  logic                   glitch_hit;
  logic                   rise_nxt;
  logic                   fall_nxt;
  logic                   db_nxt;

  // Stage p0: metastability synchroniser; raw_in is used nowhere else
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_p0 <= {SYNC_STAGES{INIT_LEVEL}};
    end else begin
      sync_p0 <= {sync_p0[SYNC_STAGES-2:0], raw_in};
    end
  end

  assign s_in = sync_p0[SYNC_STAGES-1];

  // Stage p1: state register and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= RESET_STATE;
      db_out     <= INIT_LEVEL;
      rise_pulse <= 1'b0;
      fall_pulse <= 1'b0;
      glitch_cnt <= '0;
    end else begin
      state      <= state_nxt;
      db_out     <= db_nxt;
      rise_pulse <= rise_nxt;
      fall_pulse <= fall_nxt;
      if (glitch_hit) begin
        glitch_cnt <= sat_inc(glitch_cnt);
      end
    end
  end

  // A level mismatch always wins over timer_done so an aborted wait never strobes
  always_comb begin
    state_nxt  = state;
    glitch_hit = 1'b0;
    rise_nxt   = 1'b0;
    fall_nxt   = 1'b0;
    case (state)
      STABLE_LOW: begin
        if (s_in) state_nxt = WAIT_HIGH;
      end
      WAIT_HIGH: begin
        if (!s_in) begin
          state_nxt  = STABLE_LOW;
          glitch_hit = 1'b1;
        end else if (timer_done) begin
          state_nxt = STABLE_HIGH;
          rise_nxt  = 1'b1;
        end
      end
      STABLE_HIGH: begin
        if (!s_in) state_nxt = WAIT_LOW;
      end
      WAIT_LOW: begin
        if (s_in) begin
          state_nxt  = STABLE_HIGH;
          glitch_hit = 1'b1;
        end else if (timer_done) begin
          state_nxt = STABLE_LOW;
          fall_nxt  = 1'b1;
        end
      end
      default: state_nxt = RESET_STATE;
    endcase
  end

  always_comb begin
    db_nxt = db_out;
    if (rise_nxt) db_nxt = 1'b1;
    if (fall_nxt) db_nxt = 1'b0;
  end

  // Moore decode so the timer clears in the same cycle a wait is left
  assign timer_en = (state == WAIT_HIGH) || (state == WAIT_LOW);

endmodule

// File: tb/tb_debounce_ctrl.sv
// Directed bench for debounce_ctrl: three instances (INIT 0, INIT 1, GLITCH_W=2),
// each paired with a timer model whose final count is F.
module tb_debounce_ctrl;

  localparam int F = 9;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [2:0] raw;
  logic [2:0] force_done;
  logic [2:0] tdone;
  logic [2:0] ten;
  logic [2:0] db;
  logic [2:0] rise;
  logic [2:0] fall;
  logic [7:0] gc0;
  logic [7:0] gc1;
  logic [1:0] gc2;

  int total = 0;
  int bad   = 0;
  int gexp0 = 0;

  always #5 clk = ~clk;

  // Timer model: counts while enabled, registered one-cycle done when count reaches F
  for (genvar i = 0; i < 3; i++) begin : g_tmr
    int   cnt = 0;
    logic dq  = 1'b0;
    always @(posedge clk) begin
      if (!ten[i]) begin
        cnt <= 0;
        dq  <= 1'b0;
      end else begin
        cnt <= cnt + 1;
        dq  <= (cnt == F);
      end
    end
    assign tdone[i] = dq | force_done[i];
  end

  debounce_ctrl #(.SYNC_STAGES(2), .INIT_LEVEL(1'b0), .GLITCH_W(8)) u0 (
    .clk(clk), .rst_n(rst_n), .raw_in(raw[0]), .timer_done(tdone[0]),
    .timer_en(ten[0]), .db_out(db[0]), .rise_pulse(rise[0]), .fall_pulse(fall[0]),
    .glitch_cnt(gc0)
  );

  debounce_ctrl #(.SYNC_STAGES(2), .INIT_LEVEL(1'b1), .GLITCH_W(8)) u1 (
    .clk(clk), .rst_n(rst_n), .raw_in(raw[1]), .timer_done(tdone[1]),
    .timer_en(ten[1]), .db_out(db[1]), .rise_pulse(rise[1]), .fall_pulse(fall[1]),
    .glitch_cnt(gc1)
  );

  debounce_ctrl #(.SYNC_STAGES(2), .INIT_LEVEL(1'b0), .GLITCH_W(2)) u2 (
    .clk(clk), .rst_n(rst_n), .raw_in(raw[2]), .timer_done(tdone[2]),
    .timer_en(ten[2]), .db_out(db[2]), .rise_pulse(rise[2]), .fall_pulse(fall[2]),
    .glitch_cnt(gc2)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n      = 1'b0;
    raw        = 3'b010;
    force_done = 3'b000;
    repeat (3) tick();
    total++; if (db[0] !== 1'b0)   begin bad++; $display("FAIL rst_db0 got=%b want=0", db[0]); end
    total++; if (ten[0] !== 1'b0)  begin bad++; $display("FAIL rst_en0 got=%b want=0", ten[0]); end
    total++; if (rise[0] !== 1'b0) begin bad++; $display("FAIL rst_rise0 got=%b want=0", rise[0]); end
    total++; if (fall[0] !== 1'b0) begin bad++; $display("FAIL rst_fall0 got=%b want=0", fall[0]); end
    total++; if (gc0 !== 8'd0)     begin bad++; $display("FAIL rst_gc0 got=%0d want=0", gc0); end
    total++; if (db[1] !== 1'b1)   begin bad++; $display("FAIL rst_db1 got=%b want=1", db[1]); end
    total++; if (ten[1] !== 1'b0)  begin bad++; $display("FAIL rst_en1 got=%b want=0", ten[1]); end
    total++; if (rise[1] !== 1'b0) begin bad++; $display("FAIL rst_rise1 got=%b want=0", rise[1]); end
    total++; if (fall[1] !== 1'b0) begin bad++; $display("FAIL rst_fall1 got=%b want=0", fall[1]); end
    total++; if (gc1 !== 8'd0)     begin bad++; $display("FAIL rst_gc1 got=%0d want=0", gc1); end
    rst_n = 1'b1;
    repeat (4) tick();
    total++; if (db[1] !== 1'b1)  begin bad++; $display("FAIL post_rst_db1 got=%b want=1", db[1]); end
    total++; if (ten[1] !== 1'b0) begin bad++; $display("FAIL post_rst_en1 got=%b want=0", ten[1]); end
    total++; if (ten[0] !== 1'b0) begin bad++; $display("FAIL post_rst_en0 got=%b want=0", ten[0]); end
  endtask

  // raw 0->1 captured at edge k=0; wait from k=2, done strobe at k=13
  task automatic test_clean_step();
    logic en_e, db_e, rise_e;
    raw[0] = 1'b1;
    for (int k = 0; k <= 14; k++) begin
      tick();
      en_e   = (k >= 2 && k <= 12);
      db_e   = (k >= 13);
      rise_e = (k == 13);
      total++; if (ten[0] !== en_e)   begin bad++; $display("FAIL step_en k=%0d got=%b want=%b", k, ten[0], en_e); end
      total++; if (db[0] !== db_e)    begin bad++; $display("FAIL step_db k=%0d got=%b want=%b", k, db[0], db_e); end
      total++; if (rise[0] !== rise_e) begin bad++; $display("FAIL step_rise k=%0d got=%b want=%b", k, rise[0], rise_e); end
      total++; if (fall[0] !== 1'b0)  begin bad++; $display("FAIL step_fall k=%0d got=%b want=0", k, fall[0]); end
    end
  endtask

  task automatic test_release();
    logic en_e, db_e, fall_e;
    raw[0] = 1'b0;
    for (int k = 0; k <= 14; k++) begin
      tick();
      en_e   = (k >= 2 && k <= 12);
      db_e   = (k < 13);
      fall_e = (k == 13);
      total++; if (ten[0] !== en_e)    begin bad++; $display("FAIL rel_en k=%0d got=%b want=%b", k, ten[0], en_e); end
      total++; if (db[0] !== db_e)     begin bad++; $display("FAIL rel_db k=%0d got=%b want=%b", k, db[0], db_e); end
      total++; if (fall[0] !== fall_e) begin bad++; $display("FAIL rel_fall k=%0d got=%b want=%b", k, fall[0], fall_e); end
      total++; if (rise[0] !== 1'b0)   begin bad++; $display("FAIL rel_rise k=%0d got=%b want=0", k, rise[0]); end
    end
  endtask

  // high 5 edges, low 3, then high: abort at k=7, final capture k=8, rise at k=21
  task automatic test_bounce();
    logic en_e, db_e, rise_e;
    for (int k = 0; k <= 22; k++) begin
      raw[0] = (k < 5) ? 1'b1 : ((k < 8) ? 1'b0 : 1'b1);
      tick();
      if (k == 7) gexp0++;
      en_e   = (k >= 2 && k <= 6) || (k >= 10 && k <= 20);
      db_e   = (k >= 21);
      rise_e = (k == 21);
      total++; if (ten[0] !== en_e)    begin bad++; $display("FAIL bnc_en k=%0d got=%b want=%b", k, ten[0], en_e); end
      total++; if (db[0] !== db_e)     begin bad++; $display("FAIL bnc_db k=%0d got=%b want=%b", k, db[0], db_e); end
      total++; if (rise[0] !== rise_e) begin bad++; $display("FAIL bnc_rise k=%0d got=%b want=%b", k, rise[0], rise_e); end
      total++; if (gc0 !== gexp0[7:0]) begin bad++; $display("FAIL bnc_gc k=%0d got=%0d want=%0d", k, gc0, gexp0); end
    end
  endtask

  task automatic test_simultaneous();
    raw[0] = 1'b1;
    tick();
    tick();
    raw[0] = 1'b0;
    tick();
    total++; if (ten[0] !== 1'b1) begin bad++; $display("FAIL sim_wait_en got=%b want=1", ten[0]); end
    tick();
    total++; if (ten[0] !== 1'b1) begin bad++; $display("FAIL sim_wait_en2 got=%b want=1", ten[0]); end
    force_done[0] = 1'b1;
    tick();
    force_done[0] = 1'b0;
    gexp0++;
    total++; if (ten[0] !== 1'b0)    begin bad++; $display("FAIL sim_en got=%b want=0", ten[0]); end
    total++; if (db[0] !== 1'b0)     begin bad++; $display("FAIL sim_db got=%b want=0", db[0]); end
    total++; if (rise[0] !== 1'b0)   begin bad++; $display("FAIL sim_rise got=%b want=0", rise[0]); end
    total++; if (gc0 !== gexp0[7:0]) begin bad++; $display("FAIL sim_gc got=%0d want=%0d", gc0, gexp0); end
    repeat (3) tick();
    force_done[0] = 1'b1;
    tick();
    force_done[0] = 1'b0;
    total++; if (ten[0] !== 1'b0)    begin bad++; $display("FAIL spur_en got=%b want=0", ten[0]); end
    total++; if (db[0] !== 1'b0)     begin bad++; $display("FAIL spur_db got=%b want=0", db[0]); end
    total++; if (gc0 !== gexp0[7:0]) begin bad++; $display("FAIL spur_gc got=%0d want=%0d", gc0, gexp0); end
    tick();
    total++; if (rise[0] !== 1'b0)   begin bad++; $display("FAIL spur_rise got=%b want=0", rise[0]); end
    total++; if (ten[0] !== 1'b0)    begin bad++; $display("FAIL spur_en2 got=%b want=0", ten[0]); end
  endtask

  task automatic test_saturation();
    int want;
    for (int n = 1; n <= 5; n++) begin
      for (int k = 0; k <= 9; k++) begin
        raw[2] = (k < 3);
        tick();
        if (k == 2) begin
          total++; if (ten[2] !== 1'b1) begin bad++; $display("FAIL sat_en n=%0d got=%b want=1", n, ten[2]); end
        end
      end
      want = (n < 3) ? n : 3;
      total++; if (gc2 !== want[1:0]) begin bad++; $display("FAIL sat_gc n=%0d got=%0d want=%0d", n, gc2, want); end
      total++; if (db[2] !== 1'b0)    begin bad++; $display("FAIL sat_db n=%0d got=%b want=0", n, db[2]); end
    end
  endtask

  task automatic test_reset_mid_wait();
    raw[2] = 1'b1;
    repeat (16) tick();
    total++; if (db[2] !== 1'b1) begin bad++; $display("FAIL mid_pre_db got=%b want=1", db[2]); end
    raw[2] = 1'b0;
    repeat (3) tick();
    total++; if (ten[2] !== 1'b1) begin bad++; $display("FAIL mid_wait_en got=%b want=1", ten[2]); end
    total++; if (db[2] !== 1'b1)  begin bad++; $display("FAIL mid_wait_db got=%b want=1", db[2]); end
    #2;
    rst_n = 1'b0;
    #1;
    total++; if (db[2] !== 1'b0)   begin bad++; $display("FAIL mid_rst_db got=%b want=0", db[2]); end
    total++; if (ten[2] !== 1'b0)  begin bad++; $display("FAIL mid_rst_en got=%b want=0", ten[2]); end
    total++; if (gc2 !== 2'd0)     begin bad++; $display("FAIL mid_rst_gc got=%0d want=0", gc2); end
    total++; if (fall[2] !== 1'b0) begin bad++; $display("FAIL mid_rst_fall got=%b want=0", fall[2]); end
    total++; if (db[1] !== 1'b1)   begin bad++; $display("FAIL mid_rst_db1 got=%b want=1", db[1]); end
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  initial begin
    test_reset();
    test_clean_step();
    test_release();
    test_bounce();
    test_release();
    test_simultaneous();
    test_saturation();
    test_reset_mid_wait();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog timeout total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

endmodule
